dmem_responder: RTL and testbench

Data-memory responder for the pipelined processor's dmem port: it services `address_dmem`/`data`/`wren` and returns `q_dmem`. Word-addressed RAM sits alongside a memory-mapped I/O page holding an LED register, a free-running cycle counter, a byte-wide transmit FIFO with a ready/valid output stream, and a synchronized switch input. It sits in the wrapper between the processor and the board-level peripherals, replacing the bare dmem RAM.

---
 rtl/dmem_responder.sv | 80 ++++++++
 tb/tb_dmem_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM plus an MMIO page (LED, cycle counter, TX FIFO, switches) on the dmem port.
// Loads are combinational from address_dmem; all state updates on the rising edge of clock.
module dmem_responder #(
    parameter int          DEPTH     = 4096,
    parameter int          TX_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE = 32'h0000_F000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [15:0] led,
    input  logic [15:0] switches,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(TX_DEPTH);
    logic [31:0]   ram [DEPTH];
    logic [7:0]    tx_buf [TX_DEPTH];
    logic [31:0]   cycle;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic          ovf;
    logic [15:0]   sw_meta, sw_sync;
    logic          is_ram, sel_led, sel_cycle, sel_txdata, sel_txstat, sel_sw;
    logic          full, empty, pop, push_req, push;
    logic [4:0]    count5;
    assign is_ram     = address_dmem < 32'(DEPTH);
    assign sel_led    = address_dmem == MMIO_BASE;
    assign sel_cycle  = address_dmem == MMIO_BASE + 32'd1;
    assign sel_txdata = address_dmem == MMIO_BASE + 32'd2;
    assign sel_txstat = address_dmem == MMIO_BASE + 32'd3;
    assign sel_sw     = address_dmem == MMIO_BASE + 32'd4;
    assign full       = count == (PW+1)'(TX_DEPTH);
    assign empty      = count == '0;
    assign tx_valid   = !empty;
    assign tx_data    = tx_buf[rd_ptr];
    assign pop        = tx_valid && tx_ready;
    assign push_req   = wren && sel_txdata;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push       = push_req && (!full || pop);
    assign count5     = 5'(count);
    always_ff @(posedge clock) begin
        if (wren && is_ram) ram[address_dmem[AW-1:0]] <= data;
        if (push) tx_buf[wr_ptr] <= data[7:0];
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led     <= '0;
            cycle   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            if (wren && sel_led) led <= data[15:0];
            cycle   <= (wren && sel_cycle) ? data : cycle + 32'd1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count   <= count + (PW+1)'(push) - (PW+1)'(pop);
            if (wren && sel_txstat) ovf <= 1'b0;
            else if (push_req && !push) ovf <= 1'b1;
            sw_meta <= switches;
            sw_sync <= sw_meta;
        end
    end
    always_comb begin
        q_dmem = is_ram     ? ram[address_dmem[AW-1:0]] :
                 sel_led    ? {16'b0, led} :
                 sel_cycle  ? cycle :
                 sel_txstat ? {24'b0, count5, ovf, empty, full} :
                 sel_sw     ? {16'b0, sw_sync} : 32'b0;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of RAM, MMIO registers and the TX stream.
// Expected loads and expected TX bytes go through scoreboard queues.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address_dmem, data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [15:0] led, switches;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    int          vectors = 0;
    int          miscompares = 0;
    int          popped = 0;
    logic [31:0] rq[$];
    logic [7:0]  txq[$];
    localparam logic [31:0] LED = 32'h0000_F000, CYC = 32'h0000_F001, TXD = 32'h0000_F002,
                            TXS = 32'h0000_F003, SW = 32'h0000_F004;

    dmem_responder dut (
        .clock(clk), .reset(rst), .address_dmem(address_dmem), .data(data), .wren(wren),
        .q_dmem(q_dmem), .led(led), .switches(switches), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        address_dmem = a;
        data = d;
        wren = 1'b1;
        cyc();
        wren = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        address_dmem = a;
        wren = 1'b0;
        #1;
        rq.push_back(exp);
        chk(tag, q_dmem, rq.pop_front());
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accepted);
        if (accepted) txq.push_back(b);
        wr(TXD, {24'b0, b});
    endtask

    // TX handshake is sampled mid-cycle; the transfer itself happens on the next rising edge.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            if (txq.size() == 0) chk("tx_unexpected", {24'b0, tx_data}, 32'hxxxx_xxxx);
            else chk("tx_byte", {24'b0, tx_data}, {24'b0, txq.pop_front()});
            popped++;
        end
    end

    initial begin
        rst = 1'b1;
        address_dmem = '0;
        data = '0;
        wren = 1'b0;
        switches = '0;
        tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        rd("rst_cycle", CYC, 32'd0);
        chk("rst_led", {16'b0, led}, 32'd0);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        rd("rst_txstat", TXS, 32'h2);
        rd("rst_sw", SW, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            rd("cycle_inc", CYC, 32'(i));
        end
        wr(CYC, 32'hFFFF_FFFE);
        rd("cycle_load", CYC, 32'hFFFF_FFFE);
        cyc();
        rd("cycle_max", CYC, 32'hFFFF_FFFF);
        cyc();
        rd("cycle_wrap", CYC, 32'd0);

        wr(32'd0, 32'h0BAD_0000);
        wr(32'd5, 32'hDEAD_BEEF);
        wr(32'd4095, 32'h0000_1234);
        rd("ram_5", 32'd5, 32'hDEAD_BEEF);
        rd("ram_top", 32'd4095, 32'h0000_1234);
        address_dmem = 32'd5;
        data = 32'h5555_5555;
        wren = 1'b1;
        #1;
        chk("ram_read_old", q_dmem, 32'hDEAD_BEEF);
        cyc();
        wren = 1'b0;
        rd("ram_5_new", 32'd5, 32'h5555_5555);
        wr(32'd4096, 32'h7777_7777);
        rd("ram_oob", 32'd4096, 32'd0);
        rd("ram_0_intact", 32'd0, 32'h0BAD_0000);
        rd("unmapped", 32'h0000_F005, 32'd0);

        wr(LED, 32'h0001_ABCD);
        chk("led_pin", {16'b0, led}, 32'h0000_ABCD);
        rd("led_read", LED, 32'h0000_ABCD);
        switches = 16'h00F0;
        rd("sw_0edge", SW, 32'd0);
        cyc();
        rd("sw_1edge", SW, 32'd0);
        cyc();
        rd("sw_2edge", SW, 32'h0000_00F0);

        for (int i = 1; i <= 9; i++) push_byte(8'(i), i <= 8);
        rd("fill_txstat", TXS, 32'h45);
        chk("fill_valid", {31'b0, tx_valid}, 32'd1);
        popped = 0;
        tx_ready = 1'b1;
        repeat (8) cyc();
        chk("drain_count", 32'(popped), 32'd8);
        chk("drain_valid", {31'b0, tx_valid}, 32'd0);
        rd("drain_txstat", TXS, 32'h06);
        tx_ready = 1'b0;
        wr(TXS, 32'd0);
        rd("ovf_clear", TXS, 32'h02);

        for (int i = 0; i < 8; i++) push_byte(8'(8'h11 + i), 1'b1);
        rd("full2_txstat", TXS, 32'h41);
        popped = 0;
        tx_ready = 1'b1;
        txq.push_back(8'hAA);
        wr(TXD, 32'h0000_00AA);
        tx_ready = 1'b0;
        rd("pushpop_txstat", TXS, 32'h41);
        tx_ready = 1'b1;
        repeat (8) cyc();
        tx_ready = 1'b0;
        chk("pushpop_count", 32'(popped), 32'd9);
        chk("pushpop_queue", 32'(txq.size()), 32'd0);
        chk("pushpop_valid", {31'b0, tx_valid}, 32'd0);

        for (int i = 0; i < 3; i++) push_byte(8'(8'h21 + i), 1'b1);
        wr(LED, 32'h0000_00FF);
        chk("pre_rst_led", {16'b0, led}, 32'h0000_00FF);
        chk("pre_rst_valid", {31'b0, tx_valid}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_valid", {31'b0, tx_valid}, 32'd0);
        chk("async_led", {16'b0, led}, 32'd0);
        rd("async_txstat", TXS, 32'h02);
        txq.delete();
        cyc();
        rst = 1'b0;
        rd("post_rst_ram5", 32'd5, 32'h5555_5555);
        rd("post_rst_top", 32'd4095, 32'h0000_1234);
        rd("post_rst_ram0", 32'd0, 32'h0BAD_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
